core_launcher: RTL and testbench

Parametrised request/acknowledge front end for the 8-bit core. It extends the single `req`/`ack` pair into NCH independent requester channels, each with its own program entry address. Requests are arbitrated round-robin and launched on the core one at a time. A watchdog aborts runs that never raise done, and each retired run reports an error flag and its cycle count. The block sits between the external requesters and the core's start/done/entry pins.

---
 rtl/core_launcher_pkg.sv | 14 +
 rtl/core_launcher_if.sv | 32 +++
 rtl/core_launcher_rr_arbiter.sv | 29 ++
 rtl/core_launcher.sv | 115 +++++++++++
 tb/tb_core_launcher.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/core_launcher_pkg.sv
// Shared types and defaults for the core launcher.
package core_launcher_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } launch_st_e;

  localparam int NCH_DEF = 4;
  localparam int T_DEF   = 10;
  localparam int CW_DEF  = 16;

endpackage

// File: rtl/core_launcher_if.sv
// Requester/core-facing signal bundle of the core launcher.
interface core_launcher_if #(
  parameter int NCH = 4,
  parameter int T   = 10,
  parameter int CW  = 16
);
  localparam int AW = $clog2(NCH);

  logic [NCH-1:0]   req;
  logic [NCH*T-1:0] entry;
  logic [CW-1:0]    timeout_limit;
  logic             core_done;
  logic             core_start;
  logic             core_abort;
  logic [T-1:0]     core_entry;
  logic [NCH-1:0]   ack;
  logic [NCH-1:0]   err;
  logic             busy;
  logic [AW-1:0]    active_ch;
  logic [CW-1:0]    last_cycles;

  // Requesters and core drive the inputs of the launcher.
  modport master (
    output req, entry, timeout_limit, core_done,
    input  core_start, core_abort, core_entry, ack, err, busy, active_ch, last_cycles
  );

  modport slave (
    input  req, entry, timeout_limit, core_done,
    output core_start, core_abort, core_entry, ack, err, busy, active_ch, last_cycles
  );
endinterface

// File: rtl/core_launcher_rr_arbiter.sv
// Combinational round-robin pick: first eligible channel after the pointer.
module core_launcher_rr_arbiter #(
  parameter int NCH = 4,
  parameter int AW  = 2
) (
  input  logic [NCH-1:0] i_elig,
  input  logic [AW-1:0]  i_ptr,
  output logic           o_vld,
  output logic [AW-1:0]  o_idx
);
  localparam int SW = AW + 1;

  logic [SW-1:0] w_sum;

  // Walk offsets from farthest to nearest so the nearest eligible channel wins.
  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    w_sum = '0;
    for (int k = NCH; k >= 1; k--) begin
      w_sum = {1'b0, i_ptr} + SW'(k);
      if (w_sum >= SW'(NCH)) w_sum = w_sum - SW'(NCH);
      if (i_elig[w_sum[AW-1:0]]) begin
        o_vld = 1'b1;
        o_idx = w_sum[AW-1:0];
      end
    end
  end
endmodule

// File: rtl/core_launcher.sv
// Multi-channel launcher: arbitrates requesters onto the core's start/done pins,
// runs a watchdog and reports per-run error flag and cycle count.
//
//   state  | meaning
//   IDLE   | waiting for an eligible channel (req high, ack low)
//   LAUNCH | one cycle, core_start pulsed with the granted entry address
//   RUN    | core running; watch for withdrawal, done or watchdog expiry
module core_launcher
  import core_launcher_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int T   = T_DEF,
  parameter int CW  = CW_DEF
) (
  input logic            Clk,
  input logic            Reset,
  core_launcher_if.slave bus
);
  localparam int AW = $clog2(NCH);

  launch_st_e     r_state, w_state_nxt;
  logic [AW-1:0]  r_active_ch, r_rr_ptr;
  logic [CW-1:0]  r_cnt, r_last_cycles, w_cnt_inc;
  logic [NCH-1:0] r_ack, r_err, w_ack_nxt, w_err_nxt, w_elig;
  logic           r_core_start, r_core_abort, w_start_nxt, w_abort_nxt;
  logic [T-1:0]   r_core_entry, w_entry_sel;
  logic           w_grant_vld, w_req_act, w_withdraw, w_done, w_tmo;
  logic [AW-1:0]  w_grant_idx;

  assign w_elig      = bus.req & ~r_ack;
  assign w_entry_sel = bus.entry[int'(w_grant_idx)*T +: T];
  // Saturating increment; also used for the watchdog compare so all-ones never wraps.
  assign w_cnt_inc   = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
  assign w_req_act   = bus.req[r_active_ch];
  assign w_withdraw  = (r_state == RUN) && !w_req_act;
  assign w_done      = (r_state == RUN) && w_req_act && bus.core_done;
  // Done on the same edge masks the timeout.
  assign w_tmo       = (r_state == RUN) && w_req_act && !bus.core_done &&
                       (bus.timeout_limit != '0) && (w_cnt_inc == bus.timeout_limit);

  core_launcher_rr_arbiter #(.NCH(NCH), .AW(AW)) u_arb (
    .i_elig (w_elig),
    .i_ptr  (r_rr_ptr),
    .o_vld  (w_grant_vld),
    .o_idx  (w_grant_idx)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_grant_vld) w_state_nxt = LAUNCH;
      LAUNCH:  w_state_nxt = RUN;
      RUN:     if (w_withdraw || w_done || w_tmo) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered pulses and per-channel ack/err flags.
  always_comb begin
    w_start_nxt = (r_state == IDLE) && w_grant_vld;
    w_abort_nxt = w_withdraw || w_tmo;
    w_ack_nxt   = r_ack & bus.req;
    w_err_nxt   = r_err & bus.req;
    if (w_done || w_tmo) begin
      w_ack_nxt[r_active_ch] = 1'b1;
      w_err_nxt[r_active_ch] = w_tmo;
    end
  end

  // Grant bookkeeping, run counter and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_active_ch   <= '0;
      r_rr_ptr      <= AW'(NCH - 1);
      r_cnt         <= '0;
      r_last_cycles <= '0;
      r_ack         <= '0;
      r_err         <= '0;
      r_core_start  <= 1'b0;
      r_core_abort  <= 1'b0;
      r_core_entry  <= '0;
    end else begin
      if (w_start_nxt) begin
        r_active_ch  <= w_grant_idx;
        r_rr_ptr     <= w_grant_idx;
        r_core_entry <= w_entry_sel;
      end
      if (r_state == LAUNCH)
        r_cnt <= '0;
      else if ((r_state == RUN) && !(w_withdraw || w_done || w_tmo))
        r_cnt <= w_cnt_inc;
      if (w_done || w_tmo) r_last_cycles <= w_cnt_inc;
      r_ack        <= w_ack_nxt;
      r_err        <= w_err_nxt;
      r_core_start <= w_start_nxt;
      r_core_abort <= w_abort_nxt;
    end
  end

  assign bus.core_start  = r_core_start;
  assign bus.core_abort  = r_core_abort;
  assign bus.core_entry  = r_core_entry;
  assign bus.ack         = r_ack;
  assign bus.err         = r_err;
  assign bus.busy        = (r_state != IDLE);
  assign bus.active_ch   = r_active_ch;
  assign bus.last_cycles = r_last_cycles;
endmodule

// File: tb/tb_core_launcher.sv
// Bench for core_launcher: table of single runs plus hand-written sequences,
// with a scoreboard of expected launches/retirements checked by a monitor.
module tb_core_launcher;
  localparam int NCH = 4;
  localparam int T   = 10;
  localparam int CW  = 16;

  typedef struct {
    int          ch;
    logic [9:0]  entry;
    logic [15:0] limit;
    int          done_n;
    logic        exp_abort;
    logic        exp_err;
    logic [15:0] exp_cyc;
  } vec_t;

  typedef struct {
    int          ch;
    logic [9:0]  entry;
    int          done_n;
    logic        abort;
    logic        ack;
    logic        err;
    logic [15:0] cyc;
    int          gap;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_launcher_if #(.NCH(NCH), .T(T), .CW(CW)) bus ();
  core_launcher #(.NCH(NCH), .T(T), .CW(CW)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];
  vec_t vecs[6];

  logic [3:0] prev_ack;
  logic       prev_start;
  logic       running;
  int         cyc, last_ret, run_c, cur_done_n;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    n_chk++;
    if (act !== req_v) $display("FAIL %s actual=%0h required=%0h", nm, act, req_v);
    else n_pass++;
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s actual=timeout_or_unexpected required=expected_event", nm);
  endtask

  task automatic push_exp(input int ch, input logic [9:0] en, input int dn, input logic ab,
                          input logic ak, input logic er, input logic [15:0] cy, input int gp);
    sb.push_back('{ch:ch, entry:en, done_n:dn, abort:ab, ack:ak, err:er, cyc:cy, gap:gp});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_start"}, {31'b0, bus.core_start}, 0);
    check({tag, "_abort"}, {31'b0, bus.core_abort}, 0);
    check({tag, "_entry"}, {22'b0, bus.core_entry}, 0);
    check({tag, "_ack"},   {28'b0, bus.ack}, 0);
    check({tag, "_err"},   {28'b0, bus.err}, 0);
    check({tag, "_busy"},  {31'b0, bus.busy}, 0);
    check({tag, "_act"},   {30'b0, bus.active_ch}, 0);
    check({tag, "_last"},  {16'b0, bus.last_cycles}, 0);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!bus.core_start && n < 20) begin @(negedge clk); n++; end
    if (!bus.core_start) fail_now("start_wait");
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin @(negedge clk); n++; end
    if (bus.busy) fail_now("idle_wait");
  endtask

  // Four-phase requester: drop req on ack, optionally re-request once afterwards.
  task automatic service(input int budget, input logic [3:0] rearm);
    int n = 0;
    logic [3:0] ra = rearm;
    while (n < budget) begin
      @(negedge clk); n++;
      for (int i = 0; i < NCH; i++) begin
        if (bus.ack[i] && bus.req[i]) bus.req[i] = 1'b0;
        else if (!bus.req[i] && !bus.ack[i] && ra[i]) begin bus.req[i] = 1'b1; ra[i] = 1'b0; end
      end
      if (bus.req == 4'b0 && !bus.busy && sb.size() == 0 && ra == 4'b0) break;
    end
    if (n >= budget) fail_now("service_budget");
  endtask

  task automatic run_vec(input vec_t v);
    bus.entry[v.ch*T +: T] = v.entry;
    bus.timeout_limit      = v.limit;
    push_exp(v.ch, v.entry, v.done_n, v.exp_abort, 1'b1, v.exp_err, v.exp_cyc, 0);
    bus.req[v.ch] = 1'b1;
    wait_start();
    wait_idle(70000);
    check("ack_held", {31'b0, bus.ack[v.ch]}, 1);
    bus.req[v.ch] = 1'b0;
    @(negedge clk);
    check("ack_cleared", {31'b0, bus.ack[v.ch]}, 0);
    check("err_cleared", {31'b0, bus.err[v.ch]}, 0);
    @(negedge clk);
  endtask

  // Core model and scoreboard monitor.
  always @(negedge clk) begin
    logic [3:0] rise;
    exp_t e;
    rise = bus.ack & ~prev_ack;
    if (!rst_n) begin
      prev_ack = '0; prev_start = 1'b0; running = 1'b0;
      bus.core_done = 1'b0; run_c = 0; cur_done_n = 0;
    end else begin
      cyc++;
      if (bus.core_start) begin
        check("start_one_cycle", {31'b0, prev_start}, 0);
        if (sb.size() == 0) fail_now("unexpected_start");
        else begin
          check("grant_ch", bus.active_ch, sb[0].ch);
          check("core_entry", {22'b0, bus.core_entry}, {22'b0, sb[0].entry});
          check("busy_launch", {31'b0, bus.busy}, 1);
          if (sb[0].gap != 0) check("idle_gap", cyc - last_ret, sb[0].gap);
          cur_done_n = sb[0].done_n;
        end
        run_c = 0; running = 1'b1;
      end else if (running) begin
        run_c++;
        if (cur_done_n != 0 && run_c == cur_done_n) bus.core_done = 1'b1;
      end
      if ((|rise) || bus.core_abort) begin
        running = 1'b0; bus.core_done = 1'b0; last_ret = cyc;
        if (sb.size() == 0) fail_now("unexpected_retire");
        else begin
          e = sb.pop_front();
          check("retire_ch", bus.active_ch, e.ch);
          check("abort", {31'b0, bus.core_abort}, {31'b0, e.abort});
          check("no_start_with_abort", {31'b0, bus.core_start}, 0);
          check("ack_rise", {31'b0, rise[e.ch]}, {31'b0, e.ack});
          check("busy_retired", {31'b0, bus.busy}, 0);
          if (e.ack) begin
            check("err", {31'b0, bus.err[e.ch]}, {31'b0, e.err});
            check("last_cycles", {16'b0, bus.last_cycles}, {16'b0, e.cyc});
          end
        end
      end
      prev_ack = bus.ack; prev_start = bus.core_start;
    end
  end

  initial begin
    cyc = 0; last_ret = 0;
    bus.req = '0; bus.entry = '0; bus.timeout_limit = '0;
    vecs[0] = '{ch:2, entry:10'h040, limit:16'd100, done_n:5,     exp_abort:1'b0, exp_err:1'b0, exp_cyc:16'd5};
    vecs[1] = '{ch:1, entry:10'h3FF, limit:16'd8,   done_n:0,     exp_abort:1'b1, exp_err:1'b1, exp_cyc:16'd8};
    vecs[2] = '{ch:3, entry:10'h155, limit:16'd6,   done_n:6,     exp_abort:1'b0, exp_err:1'b0, exp_cyc:16'd6};
    vecs[3] = '{ch:0, entry:10'h2AA, limit:16'd1,   done_n:0,     exp_abort:1'b1, exp_err:1'b1, exp_cyc:16'd1};
    vecs[4] = '{ch:1, entry:10'h001, limit:16'd0,   done_n:1,     exp_abort:1'b0, exp_err:1'b0, exp_cyc:16'd1};
    vecs[5] = '{ch:0, entry:10'h123, limit:16'd0,   done_n:65600, exp_abort:1'b0, exp_err:1'b0, exp_cyc:16'hFFFF};

    #23;
    check_zero("por");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Withdrawal of channel 1 on its third RUN edge; pending channel 3 goes next.
    bus.entry[1*T +: T] = 10'h0AB;
    bus.entry[3*T +: T] = 10'h0CD;
    bus.timeout_limit   = 16'd0;
    push_exp(1, 10'h0AB, 0, 1'b1, 1'b0, 1'b0, 16'd0, 0);
    push_exp(3, 10'h0CD, 2, 1'b0, 1'b1, 1'b0, 16'd2, 1);
    bus.req[1] = 1'b1;
    wait_start();
    bus.req[3] = 1'b1;
    repeat (3) @(negedge clk);
    bus.req[1] = 1'b0;
    service(100, 4'b0000);
    check("withdraw_no_ack", {31'b0, bus.ack[1]}, 0);

    // Asynchronous reset in the middle of a run.
    bus.entry[2*T +: T] = 10'h200;
    push_exp(2, 10'h200, 0, 1'b0, 1'b1, 1'b0, 16'd0, 0);
    bus.req[2] = 1'b1;
    wait_start();
    repeat (4) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    sb.delete();
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.entry[0*T +: T] = 10'h111;
    bus.entry[3*T +: T] = 10'h333;
    bus.timeout_limit   = 16'd50;
    push_exp(0, 10'h111, 3, 1'b0, 1'b1, 1'b0, 16'd3, 0);
    push_exp(3, 10'h333, 4, 1'b0, 1'b1, 1'b0, 16'd4, 1);
    bus.req = 4'b1001;
    service(200, 4'b0000);

    // Round-robin with all channels requesting; channel 0 re-requests once.
    bus.entry = {10'h0FF, 10'h030, 10'h020, 10'h010};
    bus.timeout_limit = 16'd100;
    push_exp(0, 10'h010, 2, 1'b0, 1'b1, 1'b0, 16'd2, 0);
    push_exp(1, 10'h020, 3, 1'b0, 1'b1, 1'b0, 16'd3, 1);
    push_exp(2, 10'h030, 1, 1'b0, 1'b1, 1'b0, 16'd1, 1);
    push_exp(3, 10'h0FF, 4, 1'b0, 1'b1, 1'b0, 16'd4, 1);
    push_exp(0, 10'h010, 2, 1'b0, 1'b1, 1'b0, 16'd2, 1);
    bus.req = 4'b1111;
    service(500, 4'b0001);

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
